// File: rtl/dense_layer_sequencer_pkg.sv
// Shared definitions for the dense-layer pipeline: sequencer state encoding
// and the address code that marks "no row selected".
package dense_layer_sequencer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int ADDR_WIDTH      = 8;
    localparam int MAX_INPUT_NODES = 255;

    // One past the last row; the weight memory answers it with an all-zero row.
    function automatic logic [ADDR_WIDTH-1:0] idle_code(input int nodes);
        return ADDR_WIDTH'(nodes);
    endfunction

endpackage

// File: rtl/dense_layer_sequencer_element_select.sv
// Picks one element out of a packed vector whose element 0 sits in the MSBs.
// Shared by the sequencer and the activation stage.
module packed_element_select #(
    parameter int WIDTH       = 32,
    parameter int COUNT       = 100,
    parameter int INDEX_WIDTH = 8
) (
    input  logic [WIDTH*COUNT-1:0] vector,
    input  logic [INDEX_WIDTH-1:0] index,
    output logic [WIDTH-1:0]       element
);

    always_comb begin
        element = '0;
        for (int k = 0; k < COUNT; k++) begin
            if (index == INDEX_WIDTH'(k)) begin
                element = vector[(COUNT-1-k)*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/dense_layer_sequencer.sv
// Walks the weight memory row by row for one dense-layer pass and pairs each
// returned row with its layer-input scalar as a valid/ready beat for the MAC array.
module dense_layer_sequencer
    import dense_layer_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int INPUT_NODES  = 100,
    parameter int OUTPUT_NODES = 32
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [DATA_WIDTH*INPUT_NODES-1:0]  in_data,
    output logic [ADDR_WIDTH-1:0]            address,
    input  logic [DATA_WIDTH*OUTPUT_NODES-1:0] weights,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_WIDTH-1:0]            out_input,
    output logic [DATA_WIDTH*OUTPUT_NODES-1:0] out_weights,
    output logic [ADDR_WIDTH-1:0]            out_index,
    output logic                             out_last,
    output logic                             busy,
    output logic                             done
);

    localparam logic [ADDR_WIDTH-1:0] IDLE_ADDR  = idle_code(INPUT_NODES);
    localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = IDLE_ADDR - ADDR_WIDTH'(1);

    state_t                          state;
    logic [ADDR_WIDTH-1:0]           issue_ptr;
    logic                            beat_valid;
    logic [DATA_WIDTH*INPUT_NODES-1:0] inputs_q;
    logic                            advance;

    assign advance = !beat_valid || out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            issue_ptr  <= IDLE_ADDR;
            beat_valid <= 1'b0;
            out_index  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            inputs_q   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        inputs_q  <= in_data;
                        issue_ptr <= '0;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    // A stall holds everything so the memory keeps re-reading the same row.
                    if (advance) begin
                        if (issue_ptr < IDLE_ADDR) begin
                            beat_valid <= 1'b1;
                            out_index  <= issue_ptr;
                            issue_ptr  <= issue_ptr + ADDR_WIDTH'(1);
                        end else begin
                            beat_valid <= 1'b0;
                            done       <= 1'b1;
                            busy       <= 1'b0;
                            state      <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign address     = (state == RUN && beat_valid && !out_ready) ? out_index : issue_ptr;
    assign out_valid   = beat_valid;
    assign out_last    = beat_valid && (out_index == LAST_INDEX);
    assign out_weights = weights;

    packed_element_select #(
        .WIDTH      (DATA_WIDTH),
        .COUNT      (INPUT_NODES),
        .INDEX_WIDTH(ADDR_WIDTH)
    ) u_input_select (
        .vector (inputs_q),
        .index  (out_index),
        .element(out_input)
    );

endmodule
